// File: rtl/riscv_fetch_ctrl.sv
// Fetch sequencer: runs the imem req/ack handshake, holds the fetched word
// until decode accepts it, and is the only source of PC load/select pulses.
module riscv_fetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_32,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    output logic        pc_load,
    output logic        pc_src,
    output logic        fault,
    output logic [31:0] retired_32
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, ERROR} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        retired_q, retired_d;
    logic               fault_q, fault_d;

    // State and datapath registers; reset lands in IDLE so every handshake
    // output is forced low while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            instr_q   <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state and outputs; imem_ack only matters in FETCH, and the PC
    // pulse is a Mealy output so the PC moves on the same edge as the accept.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        fault_d     = fault_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        pc_load     = 1'b0;
        pc_src      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                // An ack on the last allowed cycle still counts.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = ERROR;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pc_load   = 1'b1;
                    pc_src    = branch_taken;
                    retired_d = retired_q + 32'd1;
                    state_d   = run ? FETCH : IDLE;
                end
            end
            ERROR: begin
                // Terminal until reset.
                fault_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_32   = instr_q;
    assign retired_32 = retired_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Directed bench for riscv_fetch_ctrl: inputs change 1ns after the rising
// edge, outputs are compared well before the next edge.
module tb_riscv_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_32;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic        pc_load;
    logic        pc_src;
    logic        fault;
    logic [31:0] retired_32;

    int n_chk = 0;
    int n_err = 0;

    riscv_fetch_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_32(instr_32), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .pc_load(pc_load), .pc_src(pc_src),
        .fault(fault), .retired_32(retired_32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; branch_taken = 1'b0;
        #2;
        chk("rst_req",     32'(imem_req), 0);
        chk("rst_valid",   32'(instr_valid), 0);
        chk("rst_pcload",  32'(pc_load), 0);
        chk("rst_pcsrc",   32'(pc_src), 0);
        chk("rst_instr",   instr_32, 0);
        chk("rst_retired", retired_32, 0);
        chk("rst_fault",   32'(fault), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("idle_req", 32'(imem_req), 0);

        // Basic fetch/issue: ack in first FETCH cycle, accept in first ISSUE cycle.
        run = 1'b1;
        tick();
        chk("t1_req", 32'(imem_req), 1);
        chk("t1_fetch_pcload", 32'(pc_load), 0);
        imem_ack = 1'b1; imem_rdata = 32'h00500093;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        chk("t1_valid", 32'(instr_valid), 1);
        chk("t1_instr", instr_32, 32'h00500093);
        chk("t1_req_issue", 32'(imem_req), 0);
        instr_ready = 1'b1; branch_taken = 1'b0;
        #1;
        chk("t1_pcload", 32'(pc_load), 1);
        chk("t1_pcsrc", 32'(pc_src), 0);
        tick();
        instr_ready = 1'b0;
        chk("t1_retired", retired_32, 1);
        chk("t1_back_fetch", 32'(imem_req), 1);
        chk("t1_pcload_after", 32'(pc_load), 0);

        // Ack after 3 wait cycles, 4-cycle decode stall, taken branch.
        tick(); tick(); tick();
        chk("t2_still_fetch", 32'(imem_req), 1);
        imem_ack = 1'b1; imem_rdata = 32'h00208133;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_stall_valid", 32'(instr_valid), 1);
            chk("t2_stall_instr", instr_32, 32'h00208133);
            chk("t2_stall_pcload", 32'(pc_load), 0);
            chk("t2_stall_pcsrc", 32'(pc_src), 0);
            if (i < 3) tick();
        end
        instr_ready = 1'b1;
        #1;
        chk("t2_pcload", 32'(pc_load), 1);
        chk("t2_pcsrc", 32'(pc_src), 1);
        tick();
        instr_ready = 1'b0; branch_taken = 1'b0;
        chk("t2_retired", retired_32, 2);
        chk("t2_pcload_after", 32'(pc_load), 0);

        // run drops during FETCH: fetch still completes, then IDLE.
        run = 1'b0;
        tick();
        chk("t4_req_held", 32'(imem_req), 1);
        imem_ack = 1'b1; imem_rdata = 32'h00000013;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b1;
        #1;
        chk("t4_pcload", 32'(pc_load), 1);
        tick();
        instr_ready = 1'b0;
        chk("t4_retired", retired_32, 3);
        chk("t4_idle_req", 32'(imem_req), 0);
        chk("t4_idle_valid", 32'(instr_valid), 0);
        tick();
        chk("t4_idle_stays", 32'(imem_req), 0);

        // Spurious ack in IDLE.
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        chk("t5_idle_instr", instr_32, 32'h00000013);
        chk("t5_idle_req", 32'(imem_req), 0);
        chk("t5_idle_valid", 32'(instr_valid), 0);

        // Spurious ack in ISSUE.
        run = 1'b1;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h11111111;
        tick();
        imem_rdata = 32'hDEADBEEF;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        chk("t5_issue_instr", instr_32, 32'h11111111);
        chk("t5_issue_valid", 32'(instr_valid), 1);
        run = 1'b0; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t5_retired", retired_32, 4);
        chk("t5_idle", 32'(imem_req), 0);

        // Ack on the final allowed FETCH cycle wins over the timeout.
        run = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("tb_edge_req", 32'(imem_req), 1);
        imem_ack = 1'b1; imem_rdata = 32'hCAFE0013;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        chk("tb_edge_fault", 32'(fault), 0);
        chk("tb_edge_valid", 32'(instr_valid), 1);
        chk("tb_edge_instr", instr_32, 32'hCAFE0013);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("tb_edge_retired", retired_32, 5);

        // Timeout: 16 FETCH cycles with no ack.
        for (int i = 0; i < 15; i++) tick();
        chk("t3_pre_fault", 32'(fault), 0);
        chk("t3_pre_req", 32'(imem_req), 1);
        tick();
        chk("t3_fault", 32'(fault), 1);
        chk("t3_req_drop", 32'(imem_req), 0);
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            tick();
            chk("t3_err_fault", 32'(fault), 1);
            chk("t3_err_req", 32'(imem_req), 0);
            chk("t3_err_valid", 32'(instr_valid), 0);
            chk("t3_err_pcload", 32'(pc_load), 0);
        end
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        chk("t3_err_instr", instr_32, 32'hCAFE0013);
        chk("t3_err_retired", retired_32, 5);
        reset = 1'b1; run = 1'b0;
        #1;
        chk("t3_rst_fault", 32'(fault), 0);
        chk("t3_rst_retired", retired_32, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t3_rst_idle", 32'(imem_req), 0);

        // Reset asserted in ISSUE while ready=1.
        run = 1'b1;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h00100073;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b1;
        #1;
        chk("t6_pre_pcload", 32'(pc_load), 1);
        reset = 1'b1;
        #1;
        chk("t6_pcload", 32'(pc_load), 0);
        chk("t6_valid", 32'(instr_valid), 0);
        chk("t6_instr", instr_32, 0);
        tick();
        chk("t6_retired", retired_32, 0);
        chk("t6_req", 32'(imem_req), 0);
        reset = 1'b0; instr_ready = 1'b0; run = 1'b0;
        tick();
        chk("t6_retired_after", retired_32, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_ctrl.md
Name: riscv_fetch_ctrl

Overview:
Fetch sequencer for the 32-bit RISC-V microprocessor. It drives the PC block's load and pcSrc controls and runs a req/ack handshake with instruction memory. It holds each fetched instruction until decode accepts it. It sits between the PC block, instruction memory and the decode stage, and it is the only source of PC updates.

Parameters:
TIMEOUT_CYCLES, 16, number of FETCH cycles without imem_ack before a fault is raised (legal range 2..255)
CNT_W, 8, width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  level; 1 = keep fetching, 0 = stop after the current instruction retires
imem_req  output  1  instruction memory request; the address is the PC block's pc_32
imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle
imem_rdata  input  32  instruction word from memory
instr_32  output  32  held instruction to decode
instr_valid  output  1  instr_32 is valid
instr_ready  input  1  decode accepts instr_32 in this cycle
branch_taken  input  1  sampled only on the accept cycle; selects PC+imm over PC+4
pc_load  output  1  to PC block load
pc_src  output  1  to PC block pcSrc
fault  output  1  sticky fetch-timeout flag
retired_32  output  32  count of accepted instructions

Behaviour:
- One clock domain (clk). reset is asynchronous and active-high. Asserting reset forces the FSM to IDLE and clears these outputs to 0: instr_32, retired_32, fault, wait counter. While reset is high, imem_req, instr_valid, pc_load and pc_src are 0.
- States: IDLE, FETCH, ISSUE, ERROR. Encoding is free.
- IDLE:
  - All handshake outputs are 0.
  - run=1 -> FETCH on the next edge.
- FETCH:
  - imem_req=1 (Moore). The wait counter increments every cycle spent in FETCH.
  - imem_ack=1: capture imem_rdata into instr_32, clear the counter, -> ISSUE.
  - No ack and counter == TIMEOUT_CYCLES-1: -> ERROR, and set fault=1.
  - If the ack arrives in the same cycle that the counter reaches TIMEOUT_CYCLES-1, the ack wins.
  - run dropping while in FETCH does not abandon the request. The fetch completes normally.
- ISSUE:
  - instr_valid=1. instr_32 stays stable until it is accepted.
  - Accept = instr_valid & instr_ready.
  - In the accept cycle, and only then:
    - pc_load=1 and pc_src=branch_taken (Mealy, combinational). The PC updates on the same edge.
    - retired_32 increments, wrapping modulo 2^32.
    - Next state is FETCH if run=1, otherwise IDLE.
  - In non-accept cycles, pc_load=0 and pc_src=0.
- ERROR:
  - imem_req=0, instr_valid=0, pc_load=0.
  - fault stays 1. Only reset exits this state; run has no effect.
- imem_ack is ignored outside FETCH. It must not change instr_32 or the state.
- Minimum loop is 2 cycles per instruction: FETCH with ack in the first cycle, then ISSUE with ready=1.
- pc_load is 1 for exactly one cycle per retired instruction and is never asserted in FETCH, IDLE or ERROR.
- Reset asserted mid-fetch or mid-issue:
  - Outputs clear immediately (asynchronous).
  - No pc_load pulse is generated.
  - A late ack after reset is released is ignored unless the FSM is in FETCH.

Test Plan:
- Reset, then run=1, ack 1 cycle after req with rdata=0x00500093, ready=1, branch_taken=0 -> instr_32=0x00500093, one pc_load pulse with pc_src=0, retired_32=1, back in FETCH.
- Ack after 3 cycles, ready held low for 4 ISSUE cycles, then ready=1 with branch_taken=1 -> instr_32 stable through the stall, exactly one pc_load with pc_src=1, retired_32 +1.
- No ack with TIMEOUT_CYCLES=16 -> fault=1 after 16 FETCH cycles, imem_req drops, later acks and run toggles have no effect; reset clears fault=0 and state to IDLE.
- run deasserted during FETCH -> the fetch completes, one accept with one pc_load, then IDLE with imem_req=0.
- Spurious ack in IDLE or ISSUE with rdata=0xDEADBEEF -> instr_32 unchanged, state unchanged.
- Reset asserted in ISSUE with ready=1 on the same cycle -> no pc_load, retired_32=0, instr_valid=0 immediately.
